if_pad_inserter: RTL

Downstream neighbour of `ifsram_rw`. Consumes the 64-bit ifmap words that `ifsram_rw` reads out of ifsram0/ifsram1 for one row-window and forwards them to the PE feeder. Inserts whole zero rows where the window state calls for vertical padding (UP_PADDING / DOWN_PADDING). Tags every output word with its row index and a window-last flag.

---
 rtl/if_pad_inserter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/if_pad_inserter.sv
// ---------------------------------------------------------------------------
// if_pad_inserter
//
// Sits between the ifsram_rw read path and the PE feeder. For one row-window
// it forwards the ifmap words read out of ifsram0/ifsram1. Where the window
// needs vertical padding, it inserts whole rows of zero words. Every output
// word is tagged with its row index inside the window and a window-last flag.
//
// Row sequence by mode (Z = inserted zero row, R = row taken from input):
//   2 UP_PADDING   : Z,R,R
//   3 THREEROW     : R,R,R
//   4 TWOROW       : R,R
//   5 ONEROW       : R
//   6 DOWN_PADDING : R,R,Z
//   Any other mode on start is illegal. It sets the sticky mode_err flag and
//   produces only a done pulse.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   start, mode      window start pulse and window state code (IDLE only)
//   in_data/valid    input word stream, in_ready = accept this cycle
//   out_data/valid   output word stream, out_ready = consumer accepts
//   out_row          row index of the output word (0..2)
//   out_pad          output word is an inserted zero word
//   out_last         last word of the window
//   busy             window in progress
//   done             one-cycle pulse when the window has fully drained
//   mode_err         sticky illegal-mode flag, cleared only by reset
//
// Build option:
//   IFPAD_SKID_EN    The output stage is a 2-entry skid buffer, so in_ready
//                    depends only on registers.
//                    Without it, the output stage is a single register and
//                    in_ready is combinational from out_ready.
// ---------------------------------------------------------------------------
module if_pad_inserter #(
    parameter int TBITS = 64,
    parameter int WPR   = 64,
    parameter int CW    = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [TBITS-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [TBITS-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_row,
    output logic             out_pad,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             mode_err
);

    localparam logic [2:0]    MODE_UP    = 3'd2;
    localparam logic [2:0]    MODE_THREE = 3'd3;
    localparam logic [2:0]    MODE_TWO   = 3'd4;
    localparam logic [2:0]    MODE_ONE   = 3'd5;
    localparam logic [2:0]    MODE_DOWN  = 3'd6;
    localparam logic [CW-1:0] LAST_WORD  = CW'(WPR - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    typedef struct packed {
        logic [TBITS-1:0] data;
        logic [1:0]       row;
        logic             pad;
        logic             last;
    } entry_t;

    state_t         r_state;
    logic [2:0]     r_mode;
    logic [1:0]     r_row;
    logic [CW-1:0]  r_wordCnt;
    logic           r_done;
    logic           r_modeErr;
    entry_t         r_head;

    logic           w_modeLegal;
    logic           w_zRow;
    logic           w_lastRow;
    logic           w_lastWord;
    logic           w_canAccept;
    logic           w_push;
    logic           w_drained;
    entry_t         w_newEntry;

    assign w_modeLegal = (mode >= MODE_UP) && (mode <= MODE_DOWN);
    assign w_zRow      = ((r_mode == MODE_UP)   && (r_row == 2'd0)) ||
                         ((r_mode == MODE_DOWN) && (r_row == 2'd2));
    assign w_lastWord  = (r_wordCnt == LAST_WORD);

    always_comb begin
        w_lastRow = 1'b0;
        case (r_mode)
            MODE_ONE:                        w_lastRow = (r_row == 2'd0);
            MODE_TWO:                        w_lastRow = (r_row == 2'd1);
            MODE_UP, MODE_THREE, MODE_DOWN:  w_lastRow = (r_row == 2'd2);
            default:                         w_lastRow = 1'b0;
        endcase
    end

    // A push happens in two cases. On an R row it needs an input handshake.
    // On a Z row it happens whenever the output stage has room.
    assign w_push   = (r_state == ST_RUN) && w_canAccept && (w_zRow || in_valid);
    assign in_ready = (r_state == ST_RUN) && !w_zRow && w_canAccept;

    assign w_newEntry.data = w_zRow ? '0 : in_data;
    assign w_newEntry.row  = r_row;
    assign w_newEntry.pad  = w_zRow;
    assign w_newEntry.last = w_lastWord && w_lastRow;

`ifdef IFPAD_SKID_EN
    entry_t      r_tail;
    logic [1:0]  r_count;
    logic        w_pop;

    // Room is judged from the registered occupancy only. A full buffer stops
    // input for one cycle, and the consumer's ready does not reach in_ready.
    assign w_canAccept = (r_count != 2'd2);
    assign w_pop       = (r_count != 2'd0) && out_ready;
    assign w_drained   = (r_count == 2'd0) || ((r_count == 2'd1) && out_ready);
    assign out_valid   = (r_count != 2'd0);

    // r_head is the entry presented to the consumer. r_tail only holds the
    // second entry while the consumer is stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= w_newEntry;
                    else                 r_tail <= w_newEntry;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= w_newEntry;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= w_newEntry;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic r_valid;

    assign w_canAccept = out_ready || !r_valid;
    assign w_drained   = !r_valid || out_ready;
    assign out_valid   = r_valid;

    // A new word may replace the held one only in the cycle it is consumed.
    // That keeps a stalled word stable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head  <= '0;
            r_valid <= 1'b0;
        end else if (w_push) begin
            r_head  <= w_newEntry;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif

    assign out_data = r_head.data;
    assign out_row  = r_head.row;
    assign out_pad  = r_head.pad;
    assign out_last = r_head.last;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign mode_err = r_modeErr;

    // Window control. The word counter advances once per push, and the row
    // index advances when the counter wraps. The push that carries the
    // window-last word hands over to DRAIN. DRAIN waits for the output stage
    // to empty before it signals done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_mode    <= 3'd0;
            r_row     <= 2'd0;
            r_wordCnt <= '0;
            r_done    <= 1'b0;
            r_modeErr <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_modeLegal) begin
                            r_mode    <= mode;
                            r_row     <= 2'd0;
                            r_wordCnt <= '0;
                            r_state   <= ST_RUN;
                        end else begin
                            r_modeErr <= 1'b1;
                            r_done    <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_push) begin
                        if (w_lastWord) begin
                            r_wordCnt <= '0;
                            if (w_lastRow) r_state <= ST_DRAIN;
                            else           r_row   <= r_row + 2'd1;
                        end else begin
                            r_wordCnt <= r_wordCnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
